// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int LEN_W_DEFAULT = 8;
    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream produced by the FIFO stream reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that absorbs the FIFO's one-cycle read latency.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] tail;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            // NOTE: the two data entries are reset because head drives m_data, which must read zero out of reset.
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) head <= din;
                    else           tail <= din;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - OCC_W'(1);
                end
                2'b11: begin
                    if (occ == OCC_W'(SKID_DEPTH)) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ == OCC_W'(SKID_DEPTH)));

    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && occ == '0));

endmodule

// File: rtl/fifo_stream_reader.sv
// Burst reader: pops cmd_len words from a synchronous FIFO and streams them out with m_last.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = LEN_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  empty,
    fifo_stream_reader_if.master  m,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = OCC_W + 1;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued;
    logic [LEN_W-1:0]      sent;
    logic                  inflight;
    logic [OCC_W-1:0]      occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  valid;
    logic                  pop;
    logic                  credit_ok;
    logic                  can_read;
    logic                  last_beat;

    fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (r_data),
        .occ  (occ),
        .head (head)
    );

    assign valid     = (occ != '0);
    assign pop       = valid && m.m_ready;
    assign last_beat = (sent == len_q - LEN_W'(1));

    // A word may be requested only if a slot is guaranteed when it lands, counting this cycle's pop.
    assign credit_ok = (CW'(occ) + CW'(inflight)) < (CW'(SKID_DEPTH) + CW'(pop));
    assign can_read  = !empty && (issued < len_q) && credit_ok;

    assign m.m_valid = valid;
    assign m.m_data  = head;
    assign m.m_last  = valid && last_beat;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        cmd_ready = 1'b0;
        r_en      = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : READ;
            end
            READ: begin
                r_en = can_read;
                if (can_read && issued == len_q - LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && last_beat) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= r_en;
            if (cmd_valid && cmd_ready) begin
                len_q  <= cmd_len;
                issued <= '0;
                sent   <= '0;
            end else begin
                if (r_en) issued <= issued + LEN_W'(1);
                if (pop)  sent   <= sent + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO model feeding the reader, scoreboard on the output stream.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len   = '0;
    logic          r_en;
    logic [DW-1:0] r_data    = '0;
    logic          empty;
    logic          busy;
    logic          done;

    int checks    = 0;
    int errors    = 0;
    int beat_cnt  = 0;
    int done_cnt  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [DW-1:0] mem [1024];
    logic [9:0]    wr_ptr = '0;
    logic [9:0]    rd_ptr = '0;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) m_if ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .r_en      (r_en),
        .r_data    (r_data),
        .empty     (empty),
        .m         (m_if),
        .busy      (busy),
        .done      (done)
    );

    // FIFO model: empty reflects current contents, data appears the cycle after r_en.
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (r_en) begin
            r_data <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 10'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.m_valid && m_if.m_ready) begin
                beat_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data %h last %b, none expected", m_if.m_data, m_if.m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_if.m_data, m_if.m_last} !== {mon_e.data, mon_e.last}) begin
                        errors++;
                        $display("FAIL beat_data: got %h last %b, expected %h last %b",
                                 m_if.m_data, m_if.m_last, mon_e.data, mon_e.last);
                    end
                end
            end
            if (r_en) begin
                checks++;
                if (empty !== 1'b0) begin
                    errors++;
                    $display("FAIL r_en_when_empty: r_en=1 with empty=%b", empty);
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 10'd1;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Leaves the caller at the start of cycle 1 (handshake cycle is cycle 0).
    task automatic issue(input logic [LW-1:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b, expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_burst(input string name, input int budget, input logic [5:0] pat);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            m_if.m_ready = pat[3'(k % 6)];
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        m_if.m_ready = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s_done_pulse: done=%b one cycle after pulse, expected 0", name, done);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        cmd_valid    = 1'b1;
        cmd_len      = 8'd5;
        m_if.m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({r_en, m_if.m_valid, m_if.m_last, busy, done, cmd_ready, m_if.m_data} !== {6'b000001, {DW{1'b0}}}) begin
                errors++;
                $display("FAIL reset_outputs: r_en,valid,last,busy,done,cmd_ready=%b data=%h, expected 000001 data 0",
                         {r_en, m_if.m_valid, m_if.m_last, busy, done, cmd_ready}, m_if.m_data);
            end
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, r_en} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: cmd_ready,busy,r_en=%b, expected 100", {cmd_ready, busy, r_en});
        end
    endtask

    task automatic test_basic();
        int b0, d0;
        logic [4:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            fifo_write(32'hA000_0000 | 32'(i));
            expect_beat(32'hA000_0000 | 32'(i), i == 3);
        end
        b0 = beat_cnt;
        d0 = done_cnt;
        m_if.m_ready = 1'b1;
        issue(8'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_v = {c <= 4, c >= 3 && c <= 6, c == 6, c == 7, c <= 7};
            checks++;
            if ({r_en, m_if.m_valid, m_if.m_last, done, busy} !== exp_v) begin
                errors++;
                $display("FAIL basic_cycle%0d: r_en,valid,last,done,busy=%b, expected %b",
                         c, {r_en, m_if.m_valid, m_if.m_last, done, busy}, exp_v);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({empty, beat_cnt - b0, done_cnt - d0} !== {1'b1, 32'd4, 32'd1}) begin
            errors++;
            $display("FAIL basic_totals: empty=%b beats=%0d dones=%0d, expected 1/4/1",
                     empty, beat_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int b0, d0;
        for (int i = 0; i < 8; i++) begin
            fifo_write(32'hB000_0000 | 32'(i));
            expect_beat(32'hB000_0000 | 32'(i), i == 7);
        end
        b0 = beat_cnt;
        d0 = done_cnt;
        issue(8'd8);
        run_burst("backpressure", 300, 6'b101001);
        checks++;
        if ({empty, beat_cnt - b0, done_cnt - d0, exp_q.size()} !== {1'b1, 32'd8, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL backpressure_totals: empty=%b beats=%0d dones=%0d pending=%0d, expected 1/8/1/0",
                     empty, beat_cnt - b0, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_underflow();
        int b0, d0;
        for (int i = 0; i < 2; i++) begin
            fifo_write(32'hD000_0000 | 32'(i));
            expect_beat(32'hD000_0000 | 32'(i), 1'b0);
        end
        b0 = beat_cnt;
        d0 = done_cnt;
        m_if.m_ready = 1'b1;
        issue(8'd5);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) begin
                checks++;
                if ({busy, r_en, done, empty, m_if.m_valid} !== 5'b10010) begin
                    errors++;
                    $display("FAIL underflow_stall: busy,r_en,done,empty,valid=%b, expected 10010",
                             {busy, r_en, done, empty, m_if.m_valid});
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 2; i < 5; i++) begin
            fifo_write(32'hD000_0000 | 32'(i));
            expect_beat(32'hD000_0000 | 32'(i), i == 4);
        end
        run_burst("underflow", 60, 6'b111111);
        checks++;
        if ({beat_cnt - b0, done_cnt - d0, exp_q.size()} !== {32'd5, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL underflow_totals: beats=%0d dones=%0d pending=%0d, expected 5/1/0",
                     beat_cnt - b0, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        logic [9:0] rd0;
        for (int i = 0; i < 8; i++) fifo_write(32'hC000_0000 | 32'(i));
        rd0 = rd_ptr;
        issue(8'd0);
        @(negedge clk);
        checks++;
        if ({r_en, m_if.m_valid, done, busy, cmd_ready} !== 5'b00110) begin
            errors++;
            $display("FAIL zero_cycle1: r_en,valid,done,busy,cmd_ready=%b, expected 00110",
                     {r_en, m_if.m_valid, done, busy, cmd_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({r_en, m_if.m_valid, done, busy, cmd_ready, rd_ptr} !== {5'b00001, rd0}) begin
            errors++;
            $display("FAIL zero_cycle2: r_en,valid,done,busy,cmd_ready=%b rd_ptr=%0d, expected 00001 rd_ptr=%0d",
                     {r_en, m_if.m_valid, done, busy, cmd_ready}, rd_ptr, rd0);
        end
    endtask

    task automatic test_reset_mid();
        int b0, d0;
        bit reached;
        for (int i = 0; i < 6; i++) expect_beat(mem[rd_ptr + 10'(i)], i == 5);
        b0 = beat_cnt;
        m_if.m_ready = 1'b1;
        issue(8'd6);
        reached = 1'b0;
        for (int k = 0; k < 30 && !reached; k++) begin
            if (beat_cnt - b0 >= 2) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        rst          = 1'b1;
        m_if.m_ready = 1'b0;
        checks++;
        if (!reached || beat_cnt - b0 != 2) begin
            errors++;
            $display("FAIL reset_mid_progress: beats=%0d before reset, expected 2", beat_cnt - b0);
        end
        @(posedge clk); #1;
        rst          = 1'b0;
        m_if.m_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({r_en, m_if.m_valid, m_if.m_last, busy, done, cmd_ready, m_if.m_data} !== {6'b000001, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_clear: r_en,valid,last,busy,done,cmd_ready=%b data=%h, expected 000001 data 0",
                     {r_en, m_if.m_valid, m_if.m_last, busy, done, cmd_ready}, m_if.m_data);
        end
        expect_beat(mem[rd_ptr], 1'b0);
        expect_beat(mem[rd_ptr + 10'd1], 1'b1);
        b0 = beat_cnt;
        d0 = done_cnt;
        issue(8'd2);
        run_burst("reset_mid", 40, 6'b111111);
        checks++;
        if ({beat_cnt - b0, done_cnt - d0, exp_q.size()} !== {32'd2, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_totals: beats=%0d dones=%0d pending=%0d, expected 2/1/0",
                     beat_cnt - b0, done_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        m_if.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_underflow();
        test_zero_len();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
